// File: rtl/dct_mul_arb.sv
// Round-robin arbiter that shares one 14x16 multiplier among NUM_REQ DCT requesters.
// A requester may hold the multiplier for a multi-beat burst until it sends a beat with last set.
module dct_mul_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int A_W     = 14,
   parameter int B_W     = 16,
   parameter int P_W     = 29
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_last,
   input  logic [NUM_REQ*A_W-1:0] req_a,
   input  logic [NUM_REQ*B_W-1:0] req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [P_W-1:0]         res_data,
   output logic [ID_W-1:0]        res_id,
   output logic                   res_last,
   output logic                   busy,
   output logic                   dbg_state
);

   // Handshake: a beat moves on a side when valid and ready are both high at the
   // rising edge; ready may depend combinationally on valid, never the other way.

   typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

   state_t                state;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       owner;
   logic [ID_W-1:0]       grant;
   logic                  found;
   int                    gsum;
   logic [2*NUM_REQ-1:0]  rot;
   logic                  can_take;
   logic [NUM_REQ-1:0]    acc;
   logic                  any_acc;
   logic [A_W-1:0]        sel_a;
   logic [B_W-1:0]        sel_b;
   logic                  sel_last;
   logic [ID_W-1:0]       sel_id;
   logic signed [A_W+B_W:0] a_ext;
   logic signed [A_W+B_W:0] b_ext;
   logic signed [A_W+B_W:0] prod;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
      if (int'(v) == NUM_REQ - 1) return '0;
      else return v + ID_W'(1);
   endfunction

   assign can_take  = ~res_valid | res_ready;
   assign busy      = (state == LOCKED) | res_valid;
   assign dbg_state = (state == LOCKED);

   // Rotate the valid vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
   assign rot = {req_valid, req_valid} >> rr_ptr;

   always_comb begin
      grant = '0;
      found = 1'b0;
      gsum  = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            gsum  = int'(rr_ptr) + k;
            if (gsum >= NUM_REQ) gsum = gsum - NUM_REQ;
            grant = ID_W'(gsum);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!ap_rst) begin
            if (state == ARB)
               req_ready[i] = found && (grant == ID_W'(i)) && can_take;
            else
               req_ready[i] = (owner == ID_W'(i)) && req_valid[i] && can_take;
         end
      end
   end

   always_comb begin
      acc      = req_valid & req_ready;
      any_acc  = |acc;
      sel_a    = '0;
      sel_b    = '0;
      sel_last = 1'b0;
      sel_id   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc[i]) begin
            sel_a    = req_a[i*A_W +: A_W];
            sel_b    = req_b[i*B_W +: B_W];
            sel_last = req_last[i];
            sel_id   = ID_W'(i);
         end
      end
   end

   // Operand a is unsigned, so it is zero-extended before the signed multiply.
   always_comb begin
      a_ext = {{(B_W+1){1'b0}}, sel_a};
      b_ext = {{(A_W+1){sel_b[B_W-1]}}, sel_b};
      prod  = a_ext * b_ext;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= ARB;
         rr_ptr    <= '0;
         owner     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         res_last  <= 1'b0;
      end else begin
         if (any_acc) begin
            res_valid <= 1'b1;
            res_data  <= prod[P_W-1:0];
            res_id    <= sel_id;
            res_last  <= sel_last;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end

         case (state)
            ARB: begin
               if (any_acc) begin
                  if (sel_last) begin
                     rr_ptr <= wrap_inc(sel_id);
                  end else begin
                     owner <= sel_id;
                     state <= LOCKED;
                  end
               end
            end
            LOCKED: begin
               // An idle owner keeps the lock; only its last beat releases it.
               if (any_acc && sel_last) begin
                  rr_ptr <= wrap_inc(owner);
                  state  <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_dct_mul_arb.sv
// Randomized and directed bench for dct_mul_arb: a reference arbiter model predicts grants,
// pushes expected products into a queue, and an independent monitor pops them on output handshakes.
module tb_dct_mul_arb;

   localparam int N    = 4;
   localparam int ID_W = 2;
   localparam int A_W  = 14;
   localparam int B_W  = 16;
   localparam int P_W  = 29;
   localparam int W    = ID_W + 1 + P_W;

   logic                 clk;
   logic                 ap_rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_last;
   logic [N*A_W-1:0]     req_a;
   logic [N*B_W-1:0]     req_b;
   logic [N-1:0]         req_ready;
   logic                 res_valid;
   logic                 res_ready;
   logic [P_W-1:0]       res_data;
   logic [ID_W-1:0]      res_id;
   logic                 res_last;
   logic                 busy;
   logic                 dbg_state;

   dct_mul_arb #(.NUM_REQ(N), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
      .ap_clk    (clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_last  (res_last),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // requester stimulus state
   logic [A_W-1:0]        op_a[N];
   logic signed [B_W-1:0] op_b[N];
   int                    blen[N];
   bit                    want[N];
   bit                    auto_mode;

   // reference model state
   int m_ptr;
   int m_owner;
   bit m_locked;
   bit m_res_valid;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = want[i];
         req_last[i]           = (blen[i] == 1);
         req_a[i*A_W +: A_W]   = op_a[i];
         req_b[i*B_W +: B_W]   = op_b[i];
      end
   endtask

   task automatic set_req(input int i, input int a, input int b, input int len);
      op_a[i] = A_W'(a);
      op_b[i] = B_W'(b);
      blen[i] = len;
      want[i] = 1'b1;
   endtask

   // driver: one clock cycle of stimulus plus model prediction
   task automatic step();
      int            g;
      bit            can_take;
      bit            last;
      logic [N-1:0]  exp_ready;
      logic [63:0]   pv;
      apply();
      #2;
      can_take = !m_res_valid || res_ready;
      g = -1;
      if (m_locked) begin
         if (want[m_owner]) g = m_owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && want[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      exp_ready = '0;
      if (g >= 0 && can_take) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(m_res_valid));
      chk("busy", 32'(busy), 32'(m_locked | m_res_valid));
      chk("fsm_locked", 32'(dbg_state), 32'(m_locked));
      if (g >= 0 && can_take) begin
         last = (blen[g] == 1);
         pv = 64'(longint'(op_a[g]) * longint'(op_b[g]));
         exp_q.push_back({ID_W'(g), last, pv[P_W-1:0]});
         if (last) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % N;
         end else begin
            m_locked = 1'b1;
            m_owner  = g;
         end
         m_res_valid = 1'b1;
         blen[g]--;
         op_a[g] = A_W'($urandom_range(0, 16383));
         op_b[g] = B_W'($urandom);
         if (blen[g] == 0) want[g] = 1'b0;
      end else if (res_ready) begin
         m_res_valid = 1'b0;
      end
      if (auto_mode) begin
         for (int i = 0; i < N; i++) begin
            if (blen[i] > 0) want[i] = ($urandom_range(0, 99) < 70);
            else if ($urandom_range(0, 99) < 20) begin
               blen[i] = $urandom_range(1, 8);
               want[i] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (auto_mode) res_ready = ($urandom_range(0, 99) < 75);
   endtask

   task automatic do_reset();
      ap_rst = 1'b1;
      apply();
      #2;
      chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      ap_rst      = 1'b0;
      m_ptr       = 0;
      m_owner     = 0;
      m_locked    = 1'b0;
      m_res_valid = 1'b0;
      exp_q.delete();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_last", 32'(res_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fsm", 32'(dbg_state), 32'd0);
   endtask

   // scoreboard monitor: pops one expected result per output handshake
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (ap_rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got id=%0d data=0x%0h with nothing expected", res_id, res_data);
            end else begin
               e = exp_q.pop_front();
               chk("result", 32'({res_id, res_last, res_data}), 32'(e));
            end
         end
      end
   end

   initial begin
      ap_rst    = 1'b1;
      res_ready = 1'b1;
      auto_mode = 1'b0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
         blen[i] = 0;
         want[i] = 1'b0;
      end
      apply();
      @(posedge clk);
      #1;
      want[0] = 1'b1;
      blen[0] = 1;
      do_reset();
      want[0] = 1'b0;
      blen[0] = 0;

      // single beat
      set_req(0, 100, -3, 1);
      step();
      chk("single_beat_data", 32'(res_data), 32'h1FFF_FED4);
      chk("single_beat_id", 32'(res_id), 32'd0);
      chk("single_beat_last", 32'(res_last), 32'd1);

      // truncation extremes
      set_req(0, 16383, -32768, 1);
      step();
      set_req(0, 0, -1, 1);
      step();
      chk("zero_product", 32'(res_data), 32'd0);

      // round robin with all requesters valid
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < N; i++)
            if (!want[i]) set_req(i, $urandom_range(0, 16383), $urandom, 1);
         step();
      end
      for (int i = 0; i < N; i++) begin
         want[i] = 1'b0;
         blen[i] = 0;
      end
      step();

      // lock: req1 bursts 8 beats with a 2-cycle stall, others contend
      do_reset();
      set_req(1, $urandom_range(0, 16383), $urandom, 8);
      step();
      set_req(0, $urandom_range(0, 16383), $urandom, 1);
      set_req(2, $urandom_range(0, 16383), $urandom, 1);
      for (int s = 0; s < 12; s++) begin
         if (blen[1] > 0) want[1] = !(s == 3 || s == 4);
         step();
      end

      // backpressure
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 16383), $urandom, 1);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      repeat (3) step();
      res_ready = 1'b1;
      repeat (2) step();
      for (int i = 0; i < N; i++) begin
         want[i] = 1'b0;
         blen[i] = 0;
      end
      repeat (2) step();

      // reset while locked with a result held
      do_reset();
      set_req(2, $urandom_range(0, 16383), $urandom, 5);
      step();
      step();
      res_ready = 1'b0;
      step();
      set_req(0, $urandom_range(0, 16383), $urandom, 1);
      do_reset();
      res_ready = 1'b1;
      step();
      step();
      for (int i = 0; i < N; i++) begin
         want[i] = 1'b0;
         blen[i] = 0;
      end
      repeat (3) step();

      // randomized traffic
      do_reset();
      auto_mode = 1'b1;
      repeat (1500) step();

      // drain
      auto_mode = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         want[i] = 1'b0;
         blen[i] = 0;
      end
      repeat (4) step();
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
